// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap controller:
// CSR addresses, cause codes, register bit positions and FSM/op encodings.
package trap_ctrl_pkg;

    localparam logic [11:0] CsrMstatus  = 12'h300;
    localparam logic [11:0] CsrMie      = 12'h304;
    localparam logic [11:0] CsrMtvec    = 12'h305;
    localparam logic [11:0] CsrMscratch = 12'h340;
    localparam logic [11:0] CsrMepc     = 12'h341;
    localparam logic [11:0] CsrMcause   = 12'h342;
    localparam logic [11:0] CsrMip      = 12'h344;
    localparam logic [11:0] CsrMhartid  = 12'hF14;

    // Exception cause codes (mcause interrupt bit clear)
    localparam logic [4:0] ExcIllegal    = 5'd2;
    localparam logic [4:0] ExcBreakpoint = 5'd3;
    localparam logic [4:0] ExcEcallM     = 5'd11;

    // Interrupt cause codes, equal to their mie/mip bit positions
    localparam logic [4:0] IrqSoft  = 5'd3;
    localparam logic [4:0] IrqTimer = 5'd7;
    localparam logic [4:0] IrqExt   = 5'd11;

    localparam int unsigned BitMie    = 3;
    localparam int unsigned BitMpie   = 7;
    localparam int unsigned BitMppLo  = 11;
    localparam int unsigned BitMppHi  = 12;
    localparam int unsigned BitIrqSw  = 3;
    localparam int unsigned BitIrqTim = 7;
    localparam int unsigned BitIrqExt = 11;

    // Compact 3-bit interrupt vectors used internally: {ext, timer, sw}
    localparam int unsigned IdxSw  = 0;
    localparam int unsigned IdxTim = 1;
    localparam int unsigned IdxExt = 2;

    typedef enum logic [1:0] {
        CsrNone  = 2'b00,
        CsrWrite = 2'b01,
        CsrSet   = 2'b10,
        CsrClear = 2'b11
    } csr_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StTrap = 2'b01,
        StRet  = 2'b10
    } trap_state_t;

endpackage

// File: rtl/trap_irq_sel.sv
// Fixed-priority interrupt selector: ext > sw > timer, gated by mstatus.MIE.
module trap_irq_sel
    import trap_ctrl_pkg::*;
(
    input  logic       mie_en_i,
    input  logic [2:0] mie_i,
    input  logic [2:0] mip_i,
    output logic       irq_valid_o,
    output logic [4:0] irq_code_o
);

    logic [2:0] active;

    assign active = mie_i & mip_i & {3{mie_en_i}};

    always_comb begin
        irq_valid_o = |active;
        irq_code_o  = '0;
        if (active[IdxExt]) begin
            irq_code_o = IrqExt;
        end else if (active[IdxSw]) begin
            irq_code_o = IrqSoft;
        end else if (active[IdxTim]) begin
            irq_code_o = IrqTimer;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller and CSR file: takes exceptions, mret and interrupts at
// instruction commit and requests PC redirection to mtvec/mepc from the control FSM.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_done,
    input  logic [XLEN-1:0] pc_curr,
    input  logic [XLEN-1:0] pc_next,
    input  logic            exc_ecall,
    input  logic            exc_ebreak,
    input  logic            exc_illegal,
    input  logic            is_mret,
    input  logic            irq_ext,
    input  logic            irq_sw,
    input  logic            irq_timer,
    input  logic            trap_ack,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            trap_pending,
    output logic            trap_finish,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc
);

    trap_state_t     state_q, state_d;
    logic            status_mie_q, status_mie_d;
    logic            status_mpie_q, status_mpie_d;
    logic [2:0]      mie_q, mie_d;
    logic [XLEN-3:0] mtvec_base_q, mtvec_base_d;
    logic [XLEN-3:0] mepc_base_q, mepc_base_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;

    csr_op_t         op;
    logic [2:0]      mip;
    logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;
    logic [XLEN-1:0] csr_wval;
    logic            csr_we;
    logic            commit, exc_any, take_exc, take_ret, take_irq;
    logic [4:0]      exc_code;
    logic            irq_valid;
    logic [4:0]      irq_code;
    logic            unused_pc_lsb;

    assign unused_pc_lsb = ^{pc_curr[1:0], pc_next[1:0]};

    assign op  = csr_op_t'(csr_op);
    assign mip = {irq_ext, irq_timer, irq_sw};

    trap_irq_sel u_irq_sel (
        .mie_en_i    (status_mie_q),
        .mie_i       (mie_q),
        .mip_i       (mip),
        .irq_valid_o (irq_valid),
        .irq_code_o  (irq_code)
    );

    // Commit-point event decode; exceptions beat mret, which beats interrupts.
    assign commit   = (state_q == StIdle) && instr_done;
    assign exc_any  = exc_ecall | exc_ebreak | exc_illegal;
    assign take_exc = commit && exc_any;
    assign take_ret = commit && !exc_any && is_mret;
    assign take_irq = commit && !exc_any && !is_mret && irq_valid;

    always_comb begin
        if (exc_ecall) begin
            exc_code = ExcEcallM;
        end else if (exc_ebreak) begin
            exc_code = ExcBreakpoint;
        end else begin
            exc_code = ExcIllegal;
        end
    end

    // CSR read mux, always presenting the pre-update value.
    always_comb begin
        mstatus_rd                    = '0;
        mstatus_rd[BitMppHi:BitMppLo] = 2'b11;
        mstatus_rd[BitMpie]           = status_mpie_q;
        mstatus_rd[BitMie]            = status_mie_q;

        mie_rd            = '0;
        mie_rd[BitIrqExt] = mie_q[IdxExt];
        mie_rd[BitIrqTim] = mie_q[IdxTim];
        mie_rd[BitIrqSw]  = mie_q[IdxSw];

        mip_rd            = '0;
        mip_rd[BitIrqExt] = mip[IdxExt];
        mip_rd[BitIrqTim] = mip[IdxTim];
        mip_rd[BitIrqSw]  = mip[IdxSw];

        case (csr_addr)
            CsrMstatus:  csr_rdata = mstatus_rd;
            CsrMie:      csr_rdata = mie_rd;
            CsrMtvec:    csr_rdata = {mtvec_base_q, 2'b00};
            CsrMscratch: csr_rdata = mscratch_q;
            CsrMepc:     csr_rdata = {mepc_base_q, 2'b00};
            CsrMcause:   csr_rdata = mcause_q;
            CsrMip:      csr_rdata = mip_rd;
            CsrMhartid:  csr_rdata = HART_ID;
            default:     csr_rdata = '0;
        endcase
    end

    always_comb begin
        case (op)
            CsrWrite: csr_wval = csr_wdata;
            CsrSet:   csr_wval = csr_rdata | csr_wdata;
            CsrClear: csr_wval = csr_rdata & ~csr_wdata;
            default:  csr_wval = csr_rdata;
        endcase
    end

    // A trapping instruction must not leave architectural side effects behind.
    assign csr_we = (op != CsrNone) && !take_exc;

    always_comb begin
        status_mie_d  = status_mie_q;
        status_mpie_d = status_mpie_q;
        mie_d         = mie_q;
        mtvec_base_d  = mtvec_base_q;
        mepc_base_d   = mepc_base_q;
        mcause_d      = mcause_q;
        mscratch_d    = mscratch_q;

        if (csr_we) begin
            case (csr_addr)
                CsrMstatus: begin
                    status_mie_d  = csr_wval[BitMie];
                    status_mpie_d = csr_wval[BitMpie];
                end
                CsrMie:      mie_d = {csr_wval[BitIrqExt], csr_wval[BitIrqTim], csr_wval[BitIrqSw]};
                CsrMtvec:    mtvec_base_d = csr_wval[XLEN-1:2];
                CsrMscratch: mscratch_d = csr_wval;
                CsrMepc:     mepc_base_d = csr_wval[XLEN-1:2];
                CsrMcause:   mcause_d = csr_wval;
                default:     ;
            endcase
        end

        // Trap bookkeeping overrides any same-cycle CSR write.
        if (take_exc) begin
            mcause_d    = {{(XLEN-5){1'b0}}, exc_code};
            mepc_base_d = pc_curr[XLEN-1:2];
        end
        if (take_irq) begin
            mcause_d    = {1'b1, {(XLEN-6){1'b0}}, irq_code};
            mepc_base_d = pc_next[XLEN-1:2];
        end
        if (take_exc || take_irq) begin
            status_mpie_d = status_mie_q;
            status_mie_d  = 1'b0;
        end
        if (take_ret) begin
            status_mie_d  = status_mpie_q;
            status_mpie_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_exc || take_irq) begin
                    state_d = StTrap;
                end else if (take_ret) begin
                    state_d = StRet;
                end
            end
            StTrap, StRet: begin
                if (trap_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        trap_pending = (state_q == StTrap);
        trap_finish  = (state_q == StRet);
        mtvec        = {mtvec_base_q, 2'b00};
        mepc         = {mepc_base_q, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mie_q         <= '0;
            mtvec_base_q  <= MTVEC_RESET[XLEN-1:2];
            mepc_base_q   <= '0;
            mcause_q      <= '0;
            mscratch_q    <= '0;
        end else begin
            state_q       <= state_d;
            status_mie_q  <= status_mie_d;
            status_mpie_q <= status_mpie_d;
            mie_q         <= mie_d;
            mtvec_base_q  <= mtvec_base_d;
            mepc_base_q   <= mepc_base_d;
            mcause_q      <= mcause_d;
            mscratch_q    <= mscratch_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected values, a negedge monitor
// drains them and also matches every trap_pending/trap_finish assertion to an expected event.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int SelRd   = 0;
    localparam int SelPend = 1;
    localparam int SelFin  = 2;
    localparam int SelTvec = 3;
    localparam int SelEpc  = 4;
    localparam int SelEvq  = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } chk_t;

    typedef struct {
        logic        fin;
        logic [31:0] epc;
        logic [31:0] tvec;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_done, exc_ecall, exc_ebreak, exc_illegal, is_mret;
    logic        irq_ext, irq_sw, irq_timer, trap_ack;
    logic [31:0] pc_curr, pc_next, csr_wdata, csr_rdata, mtvec, mepc;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic        trap_pending, trap_finish;

    chk_t sb_q[$];
    evt_t ev_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    logic pend_prev = 1'b0;
    logic fin_prev  = 1'b0;

    always #5 clk = ~clk;

    trap_ctrl #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0103),
        .HART_ID     (32'h0000_0005)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_done   (instr_done),
        .pc_curr      (pc_curr),
        .pc_next      (pc_next),
        .exc_ecall    (exc_ecall),
        .exc_ebreak   (exc_ebreak),
        .exc_illegal  (exc_illegal),
        .is_mret      (is_mret),
        .irq_ext      (irq_ext),
        .irq_sw       (irq_sw),
        .irq_timer    (irq_timer),
        .trap_ack     (trap_ack),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .trap_pending (trap_pending),
        .trap_finish  (trap_finish),
        .mtvec        (mtvec),
        .mepc         (mepc)
    );

    // Monitor
    always @(negedge clk) begin
        chk_t        c;
        evt_t        e;
        logic [31:0] act;
        while (sb_q.size() != 0) begin
            c = sb_q.pop_front();
            case (c.sel)
                SelRd:   act = csr_rdata;
                SelPend: act = {31'b0, trap_pending};
                SelFin:  act = {31'b0, trap_finish};
                SelTvec: act = mtvec;
                SelEpc:  act = mepc;
                SelEvq:  act = 32'(ev_q.size());
                default: act = 'x;
            endcase
            n_checks++;
            if (act !== c.val) begin
                n_errs++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", c.name, act, c.val);
            end
        end
        if ((trap_pending === 1'b1 && !pend_prev) || (trap_finish === 1'b1 && !fin_prev)) begin
            n_checks++;
            if (ev_q.size() == 0) begin
                n_errs++;
                $display("FAIL unexpected_event: pending=%0b finish=%0b, expected none",
                         trap_pending, trap_finish);
            end else begin
                e = ev_q.pop_front();
                if (trap_finish !== e.fin || mepc !== e.epc || mtvec !== e.tvec) begin
                    n_errs++;
                    $display("FAIL event: finish=%0b mepc=0x%08h mtvec=0x%08h, expected %0b 0x%08h 0x%08h",
                             trap_finish, mepc, mtvec, e.fin, e.epc, e.tvec);
                end
            end
        end
        if (trap_pending === 1'b1 && trap_finish === 1'b1) begin
            n_checks++;
            n_errs++;
            $display("FAIL exclusive: pending=1 finish=1, expected at most one");
        end
        pend_prev = (trap_pending === 1'b1);
        fin_prev  = (trap_finish === 1'b1);
    end

    task automatic ck(input string name, input int sel, input logic [31:0] val);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.val  = val;
        sb_q.push_back(c);
    endtask

    task automatic expect_evt(input logic fin, input logic [31:0] epc, input logic [31:0] tvec);
        evt_t e;
        e.fin  = fin;
        e.epc  = epc;
        e.tvec = tvec;
        ev_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        instr_done  = 1'b0;
        exc_ecall   = 1'b0;
        exc_ebreak  = 1'b0;
        exc_illegal = 1'b0;
        is_mret     = 1'b0;
        trap_ack    = 1'b0;
        csr_op      = 2'b00;
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] val);
        csr_addr = addr;
        ck(name, SelRd, val);
        step();
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = data;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        {instr_done, exc_ecall, exc_ebreak, exc_illegal, is_mret} = '0;
        {irq_ext, irq_sw, irq_timer, trap_ack} = '0;
        pc_curr = '0; pc_next = '0; csr_wdata = '0; csr_op = '0; csr_addr = '0;
        step();
        step();
        rst_n = 1'b1;

        ck("rst_pend", SelPend, 0);
        ck("rst_fin", SelFin, 0);
        ck("rst_mtvec_out", SelTvec, 32'h100);
        ck("rst_mepc_out", SelEpc, 0);
        rd("rst_mstatus", CsrMstatus, 32'h1800);
        rd("rst_mie", CsrMie, 0);
        rd("rst_mcause", CsrMcause, 0);

        csr(2'b01, CsrMtvec, 32'h1237);
        rd("mtvec_lsb", CsrMtvec, 32'h1234);
        csr(2'b01, CsrMtvec, 32'h200);
        ck("mtvec_out", SelTvec, 32'h200);
        csr(2'b01, CsrMepc, 32'h303);
        rd("mepc_lsb", CsrMepc, 32'h300);
        csr(2'b01, CsrMscratch, 32'h1234_5678);
        rd("mscratch", CsrMscratch, 32'h1234_5678);
        csr(2'b10, CsrMie, 32'h80);
        rd("mie_set", CsrMie, 32'h80);
        csr(2'b11, CsrMie, 32'h80);
        rd("mie_clr", CsrMie, 0);
        csr(2'b01, CsrMie, 32'hFFFF_FFFF);
        rd("mie_mask", CsrMie, 32'h888);
        csr(2'b01, CsrMhartid, 32'h55);
        rd("mhartid", CsrMhartid, 32'h5);
        rd("unmapped", 12'h7C0, 0);
        csr(2'b10, CsrMstatus, 32'h8);
        rd("mstatus_mie", CsrMstatus, 32'h1808);

        // ecall
        instr_done = 1'b1; exc_ecall = 1'b1; pc_curr = 32'h100; pc_next = 32'h104;
        ck("ecall_pend_lat", SelPend, 0);
        expect_evt(1'b0, 32'h100, 32'h200);
        step();
        ck("ecall_pend", SelPend, 1);
        rd("ecall_mcause", CsrMcause, 32'd11);
        rd("ecall_mepc", CsrMepc, 32'h100);
        instr_done = 1'b1; exc_ebreak = 1'b1; pc_curr = 32'h500;
        rd("ecall_mstatus", CsrMstatus, 32'h1880);
        rd("ignored_done", CsrMcause, 32'd11);
        ck("ecall_hold", SelPend, 1);
        trap_ack = 1'b1;
        step();
        ck("ecall_ack", SelPend, 0);

        // mret
        instr_done = 1'b1; is_mret = 1'b1; pc_curr = 32'h200;
        expect_evt(1'b1, 32'h100, 32'h200);
        step();
        ck("mret_fin", SelFin, 1);
        ck("mret_pend", SelPend, 0);
        rd("mret_mstatus", CsrMstatus, 32'h1888);
        trap_ack = 1'b1;
        step();
        ck("mret_ack", SelFin, 0);

        // interrupt: ext beats timer
        irq_timer = 1'b1; irq_ext = 1'b1;
        rd("mip", CsrMip, 32'h880);
        instr_done = 1'b1; pc_curr = 32'h40; pc_next = 32'h44;
        expect_evt(1'b0, 32'h44, 32'h200);
        step();
        irq_ext = 1'b0;
        rd("irq_mcause", CsrMcause, 32'h8000_000B);
        rd("irq_mepc", CsrMepc, 32'h44);
        rd("irq_mstatus", CsrMstatus, 32'h1880);
        rd("irq_drop", CsrMcause, 32'h8000_000B);
        trap_ack = 1'b1;
        step();
        irq_timer = 1'b0;
        ck("irq_ack", SelPend, 0);

        // MIE=0 masks a pending, enabled interrupt
        irq_ext = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr_done = 1'b1; pc_next = 32'h1000 + 32'(i * 4);
            ck("masked_irq", SelPend, 0);
            step();
        end
        ck("masked_irq_end", SelPend, 0);
        step();
        irq_ext = 1'b0;

        // ebreak+illegal with a CSR write in the same cycle
        instr_done = 1'b1; exc_ebreak = 1'b1; exc_illegal = 1'b1; pc_curr = 32'h300;
        csr_op = 2'b01; csr_addr = CsrMscratch; csr_wdata = 32'hDEAD;
        expect_evt(1'b0, 32'h300, 32'h200);
        step();
        rd("exc_csr_suppr", CsrMscratch, 32'h1234_5678);
        rd("ebreak_prio", CsrMcause, 32'd3);
        rd("exc_mstatus", CsrMstatus, 32'h1800);
        trap_ack = 1'b1;
        step();
        ck("exc_ack", SelPend, 0);

        // interrupt with a CSR write in the same cycle
        csr(2'b10, CsrMstatus, 32'h8);
        irq_sw = 1'b1;
        instr_done = 1'b1; pc_curr = 32'h7C; pc_next = 32'h80;
        csr_op = 2'b01; csr_addr = CsrMscratch; csr_wdata = 32'hCAFE;
        expect_evt(1'b0, 32'h80, 32'h200);
        step();
        rd("irq_csr_applied", CsrMscratch, 32'hCAFE);
        rd("sw_mcause", CsrMcause, 32'h8000_0003);
        ck("sw_pend", SelPend, 1);
        rd("sw_mstatus", CsrMstatus, 32'h1880);

        // reset while trap_pending
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        irq_sw = 1'b0;
        ck("rst2_pend", SelPend, 0);
        ck("rst2_mtvec_out", SelTvec, 32'h100);
        ck("rst2_mepc_out", SelEpc, 0);
        rd("rst2_mstatus", CsrMstatus, 32'h1800);
        rd("rst2_mcause", CsrMcause, 0);
        rd("rst2_mscratch", CsrMscratch, 0);
        rd("rst2_mie", CsrMie, 0);
        rd("rst2_mepc", CsrMepc, 0);
        ck("events_drained", SelEvq, 0);
        step();
        step();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
